// File: rtl/maxpool_win_pkg.sv
// ---------------------------------------------------------------------------
// maxpool_win_pkg
// Shared definitions for the max/average pooling window block.
//   DW_DEFAULT  : default signed sample width used by the pooling modules
//   pool_mode_e : pooling mode encoding (MODE_MAX = 0, MODE_AVG = 1)
//   clog2_min1  : ceil(log2(n)) but never less than 1, for index ports
// ---------------------------------------------------------------------------
package maxpool_win_pkg;

    localparam int DW_DEFAULT = 16;

    typedef enum logic {
        MODE_MAX = 1'b0,
        MODE_AVG = 1'b1
    } pool_mode_e;

    // A single channel still needs a 1-bit index port.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxpool_win_pool_alu.sv
// ---------------------------------------------------------------------------
// pool_alu
// Combinational update of one accumulator lane with one incoming sample.
//   load     : first sample of a window, accumulator takes the sample
//   mode     : MODE_MAX keeps the signed larger value, MODE_AVG adds
//   acc      : current accumulator value (AW bits, signed)
//   sample   : incoming sample (DW bits, signed)
//   acc_next : updated accumulator value
// ---------------------------------------------------------------------------
module pool_alu
    import maxpool_win_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = DW + 2
) (
    input  logic                 load,
    input  pool_mode_e           mode,
    input  logic signed [AW-1:0] acc,
    input  logic signed [DW-1:0] sample,
    output logic signed [AW-1:0] acc_next
);

    logic signed [AW-1:0] sample_ext;

    always_comb begin
        sample_ext = {{(AW-DW){sample[DW-1]}}, sample};
        acc_next   = acc;
        if (load) begin
            acc_next = sample_ext;
        end else if (mode == MODE_AVG) begin
            acc_next = acc + sample_ext;
        end else if (sample_ext > acc) begin
            acc_next = sample_ext;
        end
    end

endmodule

// File: rtl/maxpool_win.sv
// ---------------------------------------------------------------------------
// maxpool_win
// Channel-interleaved pooling: each window holds POOL samples for each of CH
// channels (ch0..chCH-1 repeated POOL times). Produces one max or average
// result per channel at the end of every window.
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset
//   i_valid : i_data carries a sample
//   i_data  : signed sample
//   i_mode  : 0 = max, 1 = average (latched at the start of each window)
//   i_flush : abort all open windows
//   o_valid : single-cycle result strobe
//   o_data  : pooled result (held while o_valid is low)
//   o_ch    : channel of o_data
//   o_last  : o_data belongs to channel CH-1
// ---------------------------------------------------------------------------
module maxpool_win
    import maxpool_win_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int CH   = 4,
    parameter int POOL = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    input  logic signed [DW-1:0]           i_data,
    input  logic                           i_mode,
    input  logic                           i_flush,
    output logic                           o_valid,
    output logic signed [DW-1:0]           o_data,
    output logic [clog2_min1(CH)-1:0]      o_ch,
    output logic                           o_last
);

    localparam int PW = $clog2(POOL);
    localparam int AW = DW + PW;
    localparam int CW = clog2_min1(CH);

    logic [CW-1:0]        ch_cnt;
    logic [PW-1:0]        win_cnt;
    logic signed [AW-1:0] acc [CH];
    pool_mode_e           mode_q;

    logic                 win_first;
    logic                 win_last;
    logic                 ch_last;
    logic signed [AW-1:0] acc_next;

    assign win_first = (win_cnt == '0);
    assign win_last  = (win_cnt == PW'(POOL - 1));
    assign ch_last   = (ch_cnt == CW'(CH - 1));

    // The latched mode only matters for non-load updates, which never occur
    // on the window's first sample, so the registered value is always current.
    pool_alu #(
        .DW (DW),
        .AW (AW)
    ) u_alu (
        .load     (win_first),
        .mode     (mode_q),
        .acc      (acc[ch_cnt]),
        .sample   (i_data),
        .acc_next (acc_next)
    );

    // Reset beats flush beats valid. Flush only clears the counters: stale
    // accumulators are harmless because the next window starts with a load.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ch_cnt  <= '0;
            win_cnt <= '0;
            mode_q  <= MODE_MAX;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_ch    <= '0;
            o_last  <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                acc[i] <= '0;
            end
        end else if (i_flush) begin
            ch_cnt  <= '0;
            win_cnt <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_valid) begin
                acc[ch_cnt] <= acc_next;
                if (win_first && ch_cnt == '0) begin
                    mode_q <= pool_mode_e'(i_mode);
                end
                if (ch_last) begin
                    ch_cnt  <= '0;
                    win_cnt <= win_last ? '0 : win_cnt + 1'b1;
                end else begin
                    ch_cnt <= ch_cnt + 1'b1;
                end
                // Final sample of the window for this channel: emit result.
                if (win_last) begin
                    o_valid <= 1'b1;
                    o_data  <= (mode_q == MODE_AVG) ? DW'(acc_next >>> PW)
                                                    : DW'(acc_next);
                    o_ch    <= ch_cnt;
                    o_last  <= ch_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool_win.sv
// ---------------------------------------------------------------------------
// tb_maxpool_win
// Directed self-checking bench for maxpool_win with DW=16, CH=2, POOL=4.
// Inputs are driven and outputs observed on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_maxpool_win;

    logic               i_clk;
    logic               i_rst;
    logic               i_valid;
    logic signed [15:0] i_data;
    logic               i_mode;
    logic               i_flush;
    logic               o_valid;
    logic signed [15:0] o_data;
    logic [0:0]         o_ch;
    logic               o_last;

    int checks;
    int errors;

    maxpool_win #(
        .DW   (16),
        .CH   (2),
        .POOL (4)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_mode  (i_mode),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_ch    (o_ch),
        .o_last  (o_last)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // One valid sample; returns on the next falling edge, where a result
    // produced by this sample is already visible.
    task automatic send(input logic signed [15:0] d);
        i_valid = 1'b1;
        i_data  = d;
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", o_valid); end
        checks++; if (o_data !== 16'sd0) begin errors++; $display("[TB] FAIL reset_data: got %0d expected 0", o_data); end
        checks++; if (o_ch !== 1'b0) begin errors++; $display("[TB] FAIL reset_ch: got %0d expected 0", o_ch); end
        checks++; if (o_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %b expected 0", o_last); end
    endtask

    // Interleaved ch0/ch1 window; checks results after the two final samples.
    task automatic run_window(input string name, input logic signed [15:0] s [8],
                              input logic signed [15:0] exp0, input logic signed [15:0] exp1);
        for (int k = 0; k < 8; k++) begin
            send(s[k]);
            checks++;
            if (o_valid !== (k >= 6)) begin
                errors++; $display("[TB] FAIL %s_valid_%0d: got %b expected %b", name, k, o_valid, (k >= 6));
            end
            if (k == 6) begin
                checks++; if (o_data !== exp0) begin errors++; $display("[TB] FAIL %s_ch0_data: got %0d expected %0d", name, o_data, exp0); end
                checks++; if (o_ch !== 1'b0 || o_last !== 1'b0) begin errors++; $display("[TB] FAIL %s_ch0_tag: got ch=%0d last=%b expected ch=0 last=0", name, o_ch, o_last); end
            end
            if (k == 7) begin
                checks++; if (o_data !== exp1) begin errors++; $display("[TB] FAIL %s_ch1_data: got %0d expected %0d", name, o_data, exp1); end
                checks++; if (o_ch !== 1'b1 || o_last !== 1'b1) begin errors++; $display("[TB] FAIL %s_ch1_tag: got ch=%0d last=%b expected ch=1 last=1", name, o_ch, o_last); end
            end
        end
    endtask

    task automatic test_max();
        logic signed [15:0] s [8];
        s = '{-16'sd5, 16'sd0, -16'sd3, 16'sd0, -16'sd9, 16'sd0, -16'sd7, 16'sd0};
        i_mode = 1'b0;
        run_window("max", s, -16'sd3, 16'sd0);
    endtask

    task automatic test_avg();
        logic signed [15:0] s [8];
        s = '{16'sd1, -16'sd1, 16'sd2, -16'sd2, 16'sd3, -16'sd3, 16'sd4, -16'sd4};
        i_mode = 1'b1;
        run_window("avg", s, 16'sd2, -16'sd3);
        @(negedge i_clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL avg_pulse: got %b expected 0", o_valid); end
        checks++; if (o_data !== -16'sd3) begin errors++; $display("[TB] FAIL avg_hold: got %0d expected -3", o_data); end
    endtask

    task automatic test_gaps();
        logic signed [15:0] s [8];
        int n;
        s = '{-16'sd5, 16'sd0, -16'sd3, 16'sd0, -16'sd9, 16'sd0, -16'sd7, 16'sd0};
        i_mode = 1'b0;
        for (int k = 0; k < 8; k++) begin
            send(s[k]);
            checks++;
            if (o_valid !== (k >= 6)) begin errors++; $display("[TB] FAIL gap_valid_%0d: got %b expected %b", k, o_valid, (k >= 6)); end
            if (k == 6) begin
                checks++; if (o_data !== -16'sd3 || o_ch !== 1'b0) begin errors++; $display("[TB] FAIL gap_ch0: got %0d ch=%0d expected -3 ch=0", o_data, o_ch); end
            end
            if (k == 7) begin
                checks++; if (o_data !== 16'sd0 || o_ch !== 1'b1 || o_last !== 1'b1) begin errors++; $display("[TB] FAIL gap_ch1: got %0d ch=%0d last=%b expected 0 ch=1 last=1", o_data, o_ch, o_last); end
            end
            if (k < 7) begin
                n = $urandom_range(1, 3);
                repeat (n) begin
                    @(negedge i_clk);
                    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL gap_idle_%0d: got %b expected 0", k, o_valid); end
                end
            end
        end
    endtask

    task automatic test_flush();
        logic signed [15:0] s [8];
        s = '{16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7};
        i_mode = 1'b0;
        send(16'sd100); send(16'sd200); send(16'sd300);
        // Flush with a coincident sample: the sample must be dropped.
        i_flush = 1'b1; i_valid = 1'b1; i_data = 16'sd500;
        @(negedge i_clk);
        i_flush = 1'b0; i_valid = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_quiet: got %b expected 0", o_valid); end
        run_window("flush", s, 16'sd7, 16'sd7);
    endtask

    task automatic test_flush_edge();
        for (int k = 0; k < 7; k++) send(16'sd5);
        checks++; if (o_valid !== 1'b1 || o_data !== 16'sd5) begin errors++; $display("[TB] FAIL fedge_ch0: got v=%b d=%0d expected v=1 d=5", o_valid, o_data); end
        // Final ch1 sample arrives with flush: its result is discarded.
        i_flush = 1'b1; i_valid = 1'b1; i_data = 16'sd9;
        @(negedge i_clk);
        i_flush = 1'b0; i_valid = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL fedge_drop: got %b expected 0", o_valid); end
        for (int k = 0; k < 8; k++) send(16'sd3);
        checks++; if (o_valid !== 1'b1 || o_data !== 16'sd3 || o_ch !== 1'b1) begin errors++; $display("[TB] FAIL fedge_restart: got v=%b d=%0d ch=%0d expected v=1 d=3 ch=1", o_valid, o_data, o_ch); end
        // A registered result survives a flush on the following cycle.
        i_flush = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL fedge_keep: got %b expected 1", o_valid); end
        @(negedge i_clk);
        i_flush = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL fedge_after: got %b expected 0", o_valid); end
    endtask

    task automatic test_mode_toggle();
        i_mode = 1'b1;
        send(16'sd4); send(16'sd2); send(16'sd8);
        i_mode = 1'b0;
        send(16'sd6); send(16'sd12); send(16'sd0); send(16'sd16);
        checks++; if (o_data !== 16'sd10) begin errors++; $display("[TB] FAIL toggle_avg_ch0: got %0d expected 10", o_data); end
        send(16'sd0);
        checks++; if (o_data !== 16'sd2) begin errors++; $display("[TB] FAIL toggle_avg_ch1: got %0d expected 2", o_data); end
        send(16'sd4); send(16'sd2); send(16'sd8); send(16'sd6);
        send(16'sd12); send(16'sd0); send(16'sd16);
        checks++; if (o_data !== 16'sd16) begin errors++; $display("[TB] FAIL toggle_max_ch0: got %0d expected 16", o_data); end
        send(16'sd0);
        checks++; if (o_data !== 16'sd6) begin errors++; $display("[TB] FAIL toggle_max_ch1: got %0d expected 6", o_data); end
    endtask

    task automatic test_reset_mid();
        logic signed [15:0] s [8];
        s = '{16'sd10, 16'sd5, 16'sd20, 16'sd5, 16'sd30, 16'sd5, 16'sd40, 16'sd5};
        i_mode = 1'b0;
        send(16'sd50); send(16'sd50); send(16'sd50);
        // Reset wins over a coincident valid sample and flush.
        i_rst = 1'b1; i_valid = 1'b1; i_flush = 1'b1; i_data = 16'sd77;
        @(negedge i_clk);
        i_rst = 1'b0; i_valid = 1'b0; i_flush = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_data !== 16'sd0) begin errors++; $display("[TB] FAIL rmid_zero: got v=%b d=%0d expected v=0 d=0", o_valid, o_data); end
        checks++; if (o_ch !== 1'b0 || o_last !== 1'b0) begin errors++; $display("[TB] FAIL rmid_tag: got ch=%0d last=%b expected 0 0", o_ch, o_last); end
        run_window("rmid", s, 16'sd40, 16'sd5);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        i_rst   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_mode  = 1'b0;
        i_flush = 1'b0;
        test_reset();
        test_max();
        test_avg();
        test_gaps();
        test_flush();
        test_flush_edge();
        test_mode_toggle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
